// File: rtl/fadd_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FP adder between NUM_REQ issue lanes.
// Lane tags ride a shift register alongside the adder so each sum lands in its lane's buffer.
module fadd_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAT     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     res_valid,
    input  logic [NUM_REQ-1:0]     res_ready,
    output logic [32*NUM_REQ-1:0]  res_data,
    output logic [31:0]            fu_in1,
    output logic [31:0]            fu_in2,
    output logic                   fu_valid,
    input  logic [31:0]            fu_out,
    output logic                   busy
);
    localparam int unsigned LW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]               state_q [NUM_REQ];
    logic [LW-1:0]            rr_q;
    logic [LAT:0]             tag_v_q;
    logic [LW-1:0]            tag_lane_q [LAT+1];
    logic [NUM_REQ-1:0][31:0] res_data_q;
    logic [31:0]              fu_in1_q;
    logic [31:0]              fu_in2_q;
    logic                     fu_valid_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [LW-1:0]      grant_idx;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic               cap_v;
    logic [LW-1:0]      cap_lane;
    logic               lanes_active;

    always_comb begin
        eligible     = '0;
        lanes_active = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i]  = req_valid[i] && (state_q[i] == IDLE);
            lanes_active = lanes_active || (state_q[i] != IDLE);
        end
    end

    always_comb begin
        int            idx;
        logic [LW-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        // Scan farthest-first so the eligible lane nearest rr overrides the others.
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx  = (int'(rr_q) + k) % int'(NUM_REQ);
            cand = LW'(idx);
            if (eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = '0;
        if (grant_any && rst_n) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign cap_v    = tag_v_q[LAT];
    assign cap_lane = tag_lane_q[LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q       <= '0;
            fu_valid_q <= 1'b0;
            fu_in1_q   <= '0;
            fu_in2_q   <= '0;
            tag_v_q    <= '0;
            for (int s = 0; s <= int'(LAT); s++) begin
                tag_lane_q[s] <= '0;
            end
        end else begin
            fu_valid_q    <= grant_any;
            tag_v_q[0]    <= grant_any;
            tag_lane_q[0] <= grant_idx;
            if (grant_any) begin
                fu_in1_q <= sel_a;
                fu_in2_q <= sel_b;
                rr_q     <= (grant_idx == LW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            for (int s = 1; s <= int'(LAT); s++) begin
                tag_v_q[s]    <= tag_v_q[s-1];
                tag_lane_q[s] <= tag_lane_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                state_q[i]    <= IDLE;
                res_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                unique case (state_q[i])
                    IDLE: if (grant[i]) state_q[i] <= BUSY;
                    BUSY: begin
                        if (cap_v && (cap_lane == LW'(i))) begin
                            state_q[i]    <= DONE;
                            res_data_q[i] <= fu_out;
                        end
                    end
                    DONE: if (res_ready[i]) state_q[i] <= IDLE;
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            res_valid[i] = (state_q[i] == DONE);
        end
    end

    assign req_ready = grant;
    assign res_data  = res_data_q;
    assign fu_in1    = fu_in1_q;
    assign fu_in2    = fu_in2_q;
    assign fu_valid  = fu_valid_q;
    assign busy      = lanes_active || (|tag_v_q);

endmodule

// File: tb/tb_fadd_scheduler.sv
// Scoreboard bench for fadd_scheduler: a LAT=2 instance with a modelled adder pipeline,
// plus a LAT=0 instance fed by a combinational adder model.
module tb_fadd_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid, req_ready, res_valid, res_ready;
    logic [32*NUM_REQ-1:0] req_a, req_b, res_data;
    logic [31:0]           fu_in1, fu_in2, fu_out;
    logic                  fu_valid, busy;

    logic [NUM_REQ-1:0]    z_req_valid, z_req_ready, z_res_valid, z_res_ready;
    logic [32*NUM_REQ-1:0] z_req_a, z_req_b, z_res_data;
    logic [31:0]           z_fu_in1, z_fu_in2, z_fu_out;
    logic                  z_fu_valid, z_busy;

    logic [31:0] add_p1 = '0;
    logic [31:0] add_p2 = '0;

    logic [31:0] exp_q [NUM_REQ][$];
    int          grant_log [$];
    int          hs_cyc [NUM_REQ];
    bit          inflight [NUM_REQ];
    bit          prev_valid [NUM_REQ];
    logic [31:0] prev_data [NUM_REQ];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    fadd_scheduler #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .fu_in1(fu_in1), .fu_in2(fu_in2), .fu_valid(fu_valid), .fu_out(fu_out), .busy(busy)
    );

    fadd_scheduler #(.NUM_REQ(NUM_REQ), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_a(z_req_a), .req_b(z_req_b),
        .res_valid(z_res_valid), .res_ready(z_res_ready), .res_data(z_res_data),
        .fu_in1(z_fu_in1), .fu_in2(z_fu_in2), .fu_valid(z_fu_valid), .fu_out(z_fu_out),
        .busy(z_busy)
    );

    // Known IEEE sums for the directed vectors; otherwise a non-commutative stand-in so
    // swapped operands are visible.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'hC0A00000 && b == 32'h40A00000) return 32'h00000000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h0F0F0F0F;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        add_p1 <= fadd_model(fu_in1, fu_in2);
        add_p2 <= add_p1;
    end
    assign fu_out   = add_p2;
    assign z_fu_out = fadd_model(z_fu_in1, z_fu_in2);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pushes expectations on handshakes, pops and compares on consumes.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                exp_q[i].delete();
                inflight[i]   = 1'b0;
                prev_valid[i] = 1'b0;
            end
        end else begin
            check_eq("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (res_valid[i] && !prev_valid[i]) begin
                    check_eq("res_spurious", 32'(inflight[i]), 32'd1);
                    if (inflight[i]) check_eq("res_latency", 32'(cyc - hs_cyc[i]), 32'(LAT + 1));
                    inflight[i] = 1'b0;
                end
                if (res_valid[i] && prev_valid[i])
                    check_eq("res_stable", res_data[32*i +: 32], prev_data[i]);
                if (res_valid[i] && res_ready[i]) begin
                    if (exp_q[i].size() == 0) check_eq("res_extra", 32'(exp_q[i].size()), 32'd1);
                    else check_eq("res_data", res_data[32*i +: 32], exp_q[i].pop_front());
                end
                if (req_valid[i] && req_ready[i]) begin
                    exp_q[i].push_back(fadd_model(req_a[32*i +: 32], req_b[32*i +: 32]));
                    hs_cyc[i]   = cyc + 1;
                    inflight[i] = 1'b1;
                    grant_log.push_back(i);
                end
                prev_valid[i] = res_valid[i];
                prev_data[i]  = res_data[32*i +: 32];
            end
        end
    end

    task automatic drive(input int n, input logic [NUM_REQ-1:0] sticky, input bit chk_bp);
        logic [NUM_REQ-1:0] hs;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (chk_bp) begin
                check_eq("bp_ready2", 32'(req_ready[2]), 32'd0);
                check_eq("bp_valid2", 32'(res_valid[2]), 32'd1);
            end
            hs = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~(hs & ~sticky);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (hs[i]) begin
                    req_a[32*i +: 32] = $urandom;
                    req_b[32*i +: 32] = $urandom;
                end
            end
        end
    endtask

    task automatic wait_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst_n       = 1'b0;
        req_valid   = '0;
        res_ready   = '1;
        z_req_valid = '0;
        z_res_ready = '1;
        tick();
        rst_n = 1'b1;
        grant_log.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int cnt;
        int nlog;
        bit seen;
        req_valid = '1;
        res_ready = '1;
        req_a = '0;
        req_b = '0;
        z_req_valid = '0;
        z_res_ready = '1;
        z_req_a = '0;
        z_req_b = '0;

        // Reset values, with every lane requesting while reset is held.
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_fu_valid", 32'(fu_valid), 32'd0);
        check_eq("rst_fu_in1", fu_in1, 32'd0);
        check_eq("rst_fu_in2", fu_in2, 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < int'(NUM_REQ); i++) check_eq("rst_res_data", res_data[32*i +: 32], 32'd0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;

        // Single op on lane 0.
        tick();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        @(negedge clk);
        check_eq("t1_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check_eq("t1_fu_valid", 32'(fu_valid), 32'd1);
        check_eq("t1_fu_in1", fu_in1, 32'h3F800000);
        check_eq("t1_fu_in2", fu_in2, 32'h40000000);
        tick();
        @(negedge clk);
        check_eq("t1_fu_valid_drop", 32'(fu_valid), 32'd0);
        wait_idle(20);

        // All four lanes at once after reset.
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        req_valid = '1;
        drive(6, 4'b0000, 1'b0);
        wait_idle(20);
        tick();
        nlog = grant_log.size();
        check_eq("t2_grant_count", 32'(nlog), 32'd4);
        for (int k = 0; k < 4 && k < nlog; k++) check_eq("t2_grant_order", 32'(grant_log[k]), 32'(k));

        // Fairness between lanes 1 and 3.
        do_reset();
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b1010;
        drive(24, 4'b1010, 1'b0);
        req_valid = '0;
        wait_idle(20);
        tick();
        nlog = grant_log.size();
        check_eq("t3_enough_grants", 32'(nlog >= 8), 32'd1);
        for (int k = 0; k < 8 && k < nlog; k++)
            check_eq("t3_alternate", 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

        // Back-pressure on lane 2 while lane 0 keeps working.
        do_reset();
        res_ready = 4'b1011;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0101;
        drive(6, 4'b0101, 1'b0);
        start = grant_log.size();
        drive(12, 4'b0101, 1'b1);
        cnt = 0;
        for (int k = start; k < grant_log.size(); k++) if (grant_log[k] == 0) cnt++;
        check_eq("t4_lane0_progress", 32'(cnt >= 2), 32'd1);
        res_ready = '1;
        req_valid = '0;
        wait_idle(20);

        // Reset one cycle after a lane 1 handshake.
        do_reset();
        req_a[63:32] = 32'h12345678;
        req_b[63:32] = 32'h9ABCDEF0;
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("t5_req_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_fu_valid", 32'(fu_valid), 32'd0);
        check_eq("t5_fu_in1", fu_in1, 32'd0);
        check_eq("t5_fu_in2", fu_in2, 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | (|res_valid);
        end
        check_eq("t5_no_res_valid", 32'(seen), 32'd0);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("t5_regrant", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        wait_idle(20);

        // LAT=0 instance: -5.0 + 5.0.
        do_reset();
        z_res_ready = '0;
        z_req_a[31:0] = 32'hC0A00000;
        z_req_b[31:0] = 32'h40A00000;
        z_req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t6_req_ready", 32'(z_req_ready), 32'd1);
        tick();
        z_req_valid = '0;
        @(negedge clk);
        check_eq("t6_fu_valid", 32'(z_fu_valid), 32'd1);
        check_eq("t6_res_not_yet", 32'(z_res_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("t6_res_valid", 32'(z_res_valid), 32'd1);
        check_eq("t6_res_data", z_res_data[31:0], 32'h00000000);
        check_eq("t6_busy", 32'(z_busy), 32'd1);
        tick();
        z_res_ready = '1;
        tick();
        @(negedge clk);
        check_eq("t6_consumed", 32'(z_res_valid), 32'd0);
        check_eq("t6_idle", 32'(z_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fadd_scheduler.md
# fadd_scheduler

Round-robin scheduler that shares one floating-point adder unit between `NUM_REQ` VLIW issue lanes. Each lane presents a pair of IEEE-754 single-precision operands through a valid/ready handshake. The block issues at most one operation per cycle to the adder, tracks in-flight operations by lane tag through a `LAT`-deep pipeline, and returns each sum into a one-entry per-lane result buffer with its own valid/ready handshake. It sits between the issue stage and the `float_add` datapath; the adder is treated as a fixed-latency unit.

## Interface
- `NUM_REQ`, 4: number of requesting lanes, legal range 2..8.
- `LAT`, 2: adder latency in cycles from `fu_valid` to a valid `fu_out`, legal range 0..7.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: lane i has an operation pending.
- `req_ready` out NUM_REQ: lane i granted this cycle; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b` in 32*NUM_REQ: lane i operands in bits [32i+31:32i].
- `res_valid` out NUM_REQ: lane i result buffer holds a sum.
- `res_ready` in NUM_REQ: lane i consumes its result.
- `res_data` out 32*NUM_REQ: lane i sum in bits [32i+31:32i].
- `fu_in1`, `fu_in2` out 32: registered adder operands.
- `fu_valid` out 1: operands on `fu_in1`/`fu_in2` are a new operation.
- `fu_out` in 32: adder result, valid `LAT` cycles after the matching `fu_valid` cycle.
- `busy` out 1: any lane not IDLE, or any tag pipeline entry valid.

## Operation
- Per-lane state machine with states IDLE, BUSY and DONE.
  - IDLE to BUSY on a handshake.
  - BUSY to DONE when the lane's tag exits the pipeline and the result is captured.
  - DONE to IDLE when `res_valid[i] & res_ready[i]`.
- Each lane has at most one operation in flight. No result can be dropped and no result FIFO is needed.
- Eligibility: lane i is eligible when `req_valid[i]` is high and lane i is IDLE.
- Arbitration: round-robin with pointer `rr` (clog2(NUM_REQ) bits).
  - The first eligible lane at or after `rr`, wrapping around, is granted.
  - On a grant g, `rr` is set to (g+1) mod NUM_REQ. `rr` is unchanged when there is no grant.
- `req_ready` is combinational and one-hot or zero. It never depends on `req_a` or `req_b`.
- On a handshake for lane g:
  - `fu_in1` and `fu_in2` are registered from `req_a[g]` and `req_b[g]`, and `fu_valid` is registered as 1.
  - Tag {valid=1, lane=g} enters stage 0 of the tag pipeline.
  - With no grant, `fu_valid` is registered as 0, and `fu_in1`/`fu_in2` hold their values.
- Tag pipeline: LAT+1 stages, shifting every cycle.
  - The final stage aligns with `fu_out` validity.
  - When the final stage is valid, `fu_out` is written into `res_data[lane]` and `res_valid[lane]` is set.
- `res_data[i]` stays stable while `res_valid[i]` is high.
- The block performs no arithmetic on the data; special values (Inf, zero, denormal) pass through unchanged.

## Timing
- Reset (`rst_n` low at a rising edge):
  - All lanes IDLE, `rr`=0, all tag stages invalid.
  - `fu_valid`=0, `fu_in1`=`fu_in2`=0.
  - `res_valid`=0, `res_data`=0, `busy`=0.
  - `req_ready` is 0 while `rst_n` is low.
- Latency: a handshake at edge E gives `fu_valid` high in the cycle after E, and `res_valid[g]` high after edge E+LAT+1.
  - With LAT=2, the result is visible 3 cycles after the handshake edge.
- Throughput: one issue per cycle across all lanes. Per lane, the next grant comes no earlier than the cycle after result consumption.
- Simultaneous events:
  - A DONE lane with `res_ready` high and `req_valid` high in the same cycle is not granted that cycle. It becomes eligible the following cycle.
  - A capture and a consume for different lanes in the same cycle are independent.
- Reset mid-operation: all in-flight tags are discarded. `fu_out` values arriving afterwards are ignored and no `res_valid` is raised.
- Back-pressure: `res_ready` held low keeps the lane in DONE. That lane is never granted, and other lanes are unaffected.

## Test plan
- Single op, lane 0, LAT=2: `req_a`=0x3F800000, `req_b`=0x40000000, handshake at edge 0 -> `fu_valid` high for exactly one cycle; `res_valid[0]` high after edge 3 with `res_data[0]`=0x40400000; `busy` drops after the consume.
- All four lanes assert `req_valid` at once after reset -> grants to lanes 0,1,2,3 on consecutive cycles; results appear on consecutive cycles, 3 cycles after their own grants.
- Fairness: lanes 1 and 3 request continuously with results consumed immediately -> grants alternate 1,3,1,3 and neither lane is starved.
- Back-pressure: lane 2 keeps `res_ready`=0 for 10 cycles while `req_valid[2]`=1 -> `req_ready[2]` stays 0 and `res_data[2]` stays stable; lane 0 continues to be issued and completed.
- Reset mid-flight: assert `rst_n`=0 for one cycle, one cycle after a lane 1 handshake -> no `res_valid` appears and all outputs return to reset values; a new request for lane 1 is granted normally afterwards.
- LAT=0 build: 0xC0A00000 + 0x40A00000 -> `res_data`=0x00000000 with `res_valid` high after handshake edge +1.
